cc_lives_controller: RTL and testbench

Sequences the frog's life cycle in the Frogger game: holds the lives counter, reacts to collision and goal events, runs a timed death/respawn phase and declares game over. Sits between the collision/goal detectors and the frog position/control logic and the display. Supplies the lives count that the zero-lives comparator and the HUD consume.

---
 rtl/cc_frogger_pkg.sv | 22 ++
 rtl/cc_lives_controller_if.sv | 39 +++
 rtl/cc_respawn_timer.sv | 29 ++
 rtl/cc_lives_controller.sv | 113 +++++++++++
 tb/tb_cc_lives_controller.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/cc_frogger_pkg.sv
// Shared constants for the Frogger lives controller: state encodings and
// default lives configuration.
package cc_frogger_pkg;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_PLAY     = 3'd1;
    localparam logic [2:0] STATE_DYING    = 3'd2;
    localparam logic [2:0] STATE_RESPAWN  = 3'd3;
    localparam logic [2:0] STATE_GAMEOVER = 3'd4;

    localparam int LIVES_INIT_DEFAULT = 3;
    localparam int LIVES_MAX_DEFAULT  = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = STATE_IDLE,
        ST_PLAY     = STATE_PLAY,
        ST_DYING    = STATE_DYING,
        ST_RESPAWN  = STATE_RESPAWN,
        ST_GAMEOVER = STATE_GAMEOVER
    } lives_state_t;

endpackage

// File: rtl/cc_lives_controller_if.sv
// Event inputs and status outputs of the lives controller, bundled so the
// game logic (master) and the controller (slave) share one connection.
interface cc_lives_controller_if #(
    parameter int LIVES_COUNTER_DATAWIDTH = 3
);
    logic                               CC_LIVES_CONTROLLER_start_InHigh;
    logic                               CC_LIVES_CONTROLLER_hit_InHigh;
    logic                               CC_LIVES_CONTROLLER_goal_InHigh;
    logic                               CC_LIVES_CONTROLLER_tick_InHigh;
    logic [LIVES_COUNTER_DATAWIDTH-1:0] CC_LIVES_CONTROLLER_lives_Out;
    logic                               CC_LIVES_CONTROLLER_freeze_OutHigh;
    logic                               CC_LIVES_CONTROLLER_respawn_OutHigh;
    logic                               CC_LIVES_CONTROLLER_gameover_OutHigh;
    logic [2:0]                         CC_LIVES_CONTROLLER_state_Out;

    modport master (
        output CC_LIVES_CONTROLLER_start_InHigh,
        output CC_LIVES_CONTROLLER_hit_InHigh,
        output CC_LIVES_CONTROLLER_goal_InHigh,
        output CC_LIVES_CONTROLLER_tick_InHigh,
        input  CC_LIVES_CONTROLLER_lives_Out,
        input  CC_LIVES_CONTROLLER_freeze_OutHigh,
        input  CC_LIVES_CONTROLLER_respawn_OutHigh,
        input  CC_LIVES_CONTROLLER_gameover_OutHigh,
        input  CC_LIVES_CONTROLLER_state_Out
    );

    modport slave (
        input  CC_LIVES_CONTROLLER_start_InHigh,
        input  CC_LIVES_CONTROLLER_hit_InHigh,
        input  CC_LIVES_CONTROLLER_goal_InHigh,
        input  CC_LIVES_CONTROLLER_tick_InHigh,
        output CC_LIVES_CONTROLLER_lives_Out,
        output CC_LIVES_CONTROLLER_freeze_OutHigh,
        output CC_LIVES_CONTROLLER_respawn_OutHigh,
        output CC_LIVES_CONTROLLER_gameover_OutHigh,
        output CC_LIVES_CONTROLLER_state_Out
    );
endinterface

// File: rtl/cc_respawn_timer.sv
// Death-phase timer: counts frame ticks while enabled, held at zero by clear.
// o_done flags the tick that brings the count to TICKS, so the owner can
// change state on that same edge.
module cc_respawn_timer #(
    parameter int TICKS = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_done
);
    localparam int TW = $clog2(TICKS + 1);
    localparam logic [TW-1:0] LAST = TW'(TICKS - 1);

    logic [TW-1:0] r_cnt;

    // Count ticks; clear dominates so a tick coinciding with entry is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TW'(TICKS))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = i_en && !i_clr && (r_cnt == LAST);

endmodule

// File: rtl/cc_lives_controller.sv
// Frogger life-cycle sequencer: lives counter, goal/bonus accounting, timed
// death phase, one-cycle respawn pulse and game-over latch. Every output is
// a register or a decode of the registered state.
module cc_lives_controller
    import cc_frogger_pkg::*;
#(
    parameter int LIVES_COUNTER_DATAWIDTH = 3,
    parameter int LIVES_INIT              = LIVES_INIT_DEFAULT,
    parameter int LIVES_MAX               = LIVES_MAX_DEFAULT,
    parameter int RESPAWN_TICKS           = 4,
    parameter int BONUS_EVERY             = 4
) (
    input  logic                  CC_LIVES_CONTROLLER_CLOCK_50,
    input  logic                  CC_LIVES_CONTROLLER_RESET_InHigh,
    cc_lives_controller_if.slave  bus
);
    localparam int LW   = LIVES_COUNTER_DATAWIDTH;
    localparam int GC_W = (BONUS_EVERY > 0) ? $clog2(BONUS_EVERY + 1) : 1;
    localparam logic [LW-1:0]   L_INIT  = LW'(LIVES_INIT);
    localparam logic [LW-1:0]   L_MAX   = LW'(LIVES_MAX);
    localparam logic [GC_W-1:0] GC_LAST = GC_W'((BONUS_EVERY > 0) ? BONUS_EVERY - 1 : 0);

    lives_state_t    r_state, w_state_nxt;
    logic [LW-1:0]   r_lives, w_lives_nxt;
    logic [GC_W-1:0] r_goals, w_goals_nxt;
    logic            w_timer_done;
    logic            w_timer_clr;

    // Timer runs only while dying; it is zero on every entry to DYING.
    assign w_timer_clr = (r_state != ST_DYING);

    cc_respawn_timer #(
        .TICKS (RESPAWN_TICKS)
    ) u_timer (
        .i_clk  (CC_LIVES_CONTROLLER_CLOCK_50),
        .i_rst  (CC_LIVES_CONTROLLER_RESET_InHigh),
        .i_clr  (w_timer_clr),
        .i_en   (bus.CC_LIVES_CONTROLLER_tick_InHigh),
        .o_done (w_timer_done)
    );

    // State, lives and goal-count registers; reset wins over any event.
    always_ff @(posedge CC_LIVES_CONTROLLER_CLOCK_50) begin
        if (CC_LIVES_CONTROLLER_RESET_InHigh) begin
            r_state <= ST_IDLE;
            r_lives <= L_INIT;
            r_goals <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_goals <= w_goals_nxt;
        end
    end

    // Next-state and lives/goal updates for each life-cycle state.
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_goals_nxt = r_goals;
        case (r_state)
            ST_IDLE: begin
                if (bus.CC_LIVES_CONTROLLER_start_InHigh) begin
                    w_lives_nxt = L_INIT;
                    w_goals_nxt = '0;
                    w_state_nxt = ST_RESPAWN;
                end
            end
            ST_PLAY: begin
                // A hit swallows a simultaneous goal.
                if (bus.CC_LIVES_CONTROLLER_hit_InHigh) begin
                    w_state_nxt = ST_DYING;
                    if (r_lives != '0) w_lives_nxt = r_lives - 1'b1;
                end else if (bus.CC_LIVES_CONTROLLER_goal_InHigh) begin
                    w_state_nxt = ST_RESPAWN;
                    if (BONUS_EVERY > 0) begin
                        if (r_goals == GC_LAST) begin
                            w_goals_nxt = '0;
                            if (r_lives < L_MAX) w_lives_nxt = r_lives + 1'b1;
                        end else begin
                            w_goals_nxt = r_goals + 1'b1;
                        end
                    end
                end
            end
            ST_DYING: begin
                if (w_timer_done) begin
                    w_state_nxt = (r_lives == '0) ? ST_GAMEOVER : ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                w_state_nxt = ST_PLAY;
            end
            ST_GAMEOVER: begin
                w_lives_nxt = '0;
                if (bus.CC_LIVES_CONTROLLER_start_InHigh) begin
                    w_lives_nxt = L_INIT;
                    w_goals_nxt = '0;
                    w_state_nxt = ST_RESPAWN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.CC_LIVES_CONTROLLER_lives_Out        = r_lives;
    assign bus.CC_LIVES_CONTROLLER_freeze_OutHigh   = (r_state != ST_PLAY);
    assign bus.CC_LIVES_CONTROLLER_respawn_OutHigh  = (r_state == ST_RESPAWN);
    assign bus.CC_LIVES_CONTROLLER_gameover_OutHigh = (r_state == ST_GAMEOVER);
    assign bus.CC_LIVES_CONTROLLER_state_Out        = r_state;

endmodule

// File: tb/tb_cc_lives_controller.sv
// Directed bench for cc_lives_controller: each stimulus cycle queues the
// hand-computed post-edge expectation; a monitor compares at the falling edge.
module tb_cc_lives_controller;

    localparam logic [2:0] I = 3'd0, P = 3'd1, D = 3'd2, R = 3'd3, G = 3'd4;

    typedef struct {
        logic [2:0] lives;
        logic [2:0] st;
        int         step;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   total  = 0;
    int   passed = 0;
    int   step   = 0;

    always #5 clk = ~clk;

    cc_lives_controller_if #(.LIVES_COUNTER_DATAWIDTH(3)) bus ();

    cc_lives_controller #(
        .LIVES_COUNTER_DATAWIDTH (3),
        .LIVES_INIT              (3),
        .LIVES_MAX               (5),
        .RESPAWN_TICKS           (4),
        .BONUS_EVERY             (4)
    ) dut (
        .CC_LIVES_CONTROLLER_CLOCK_50     (clk),
        .CC_LIVES_CONTROLLER_RESET_InHigh (rst),
        .bus                              (bus)
    );

    // Monitor: compare one queued expectation per cycle against the DUT.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ef, er, eg;
            e  = q.pop_front();
            ef = (e.st != P);
            er = (e.st == R);
            eg = (e.st == G);
            total++;
            if (bus.CC_LIVES_CONTROLLER_lives_Out        === e.lives &&
                bus.CC_LIVES_CONTROLLER_state_Out        === e.st    &&
                bus.CC_LIVES_CONTROLLER_freeze_OutHigh   === ef      &&
                bus.CC_LIVES_CONTROLLER_respawn_OutHigh  === er      &&
                bus.CC_LIVES_CONTROLLER_gameover_OutHigh === eg) begin
                passed++;
            end else begin
                $display("FAIL step%0d: got lives=%0d st=%0d frz=%b rsp=%b go=%b, want lives=%0d st=%0d frz=%b rsp=%b go=%b",
                         e.step, bus.CC_LIVES_CONTROLLER_lives_Out, bus.CC_LIVES_CONTROLLER_state_Out,
                         bus.CC_LIVES_CONTROLLER_freeze_OutHigh, bus.CC_LIVES_CONTROLLER_respawn_OutHigh,
                         bus.CC_LIVES_CONTROLLER_gameover_OutHigh, e.lives, e.st, ef, er, eg);
            end
        end
    end

    // One clock: drive inputs for the edge, then queue the post-edge expectation.
    task automatic v(input logic r, input logic st, input logic h, input logic g,
                     input logic t, input logic [2:0] lv, input logic [2:0] s);
        exp_t e;
        @(negedge clk);
        rst = r;
        bus.CC_LIVES_CONTROLLER_start_InHigh = st;
        bus.CC_LIVES_CONTROLLER_hit_InHigh   = h;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = g;
        bus.CC_LIVES_CONTROLLER_tick_InHigh  = t;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        bus.CC_LIVES_CONTROLLER_hit_InHigh   = 1'b0;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b0;
        bus.CC_LIVES_CONTROLLER_tick_InHigh  = 1'b0;
        step++;
        e.lives = lv;
        e.st    = s;
        e.step  = step;
        q.push_back(e);
    endtask

    // Goal from PLAY: RESPAWN with the expected lives, then back to PLAY.
    task automatic goal(input logic [2:0] lv);
        v(0, 0, 0, 1, 0, lv, R);
        v(0, 0, 0, 0, 0, lv, P);
    endtask

    // Hit from PLAY and a full four-tick death phase.
    task automatic death(input logic [2:0] lv);
        v(0, 0, 1, 0, 0, lv, D);
        v(0, 0, 0, 0, 1, lv, D);
        v(0, 0, 0, 0, 1, lv, D);
        v(0, 0, 0, 0, 1, lv, D);
        if (lv == 3'd0) begin
            v(0, 0, 0, 0, 1, 3'd0, G);
        end else begin
            v(0, 0, 0, 0, 1, lv, R);
            v(0, 0, 0, 0, 0, lv, P);
        end
    endtask

    initial begin
        bus.CC_LIVES_CONTROLLER_start_InHigh = 1'b0;
        bus.CC_LIVES_CONTROLLER_hit_InHigh   = 1'b0;
        bus.CC_LIVES_CONTROLLER_goal_InHigh  = 1'b0;
        bus.CC_LIVES_CONTROLLER_tick_InHigh  = 1'b0;

        // reset, IDLE ignores events, start
        v(1, 0, 0, 0, 0, 3, I);
        v(0, 0, 1, 1, 1, 3, I);
        v(0, 1, 0, 0, 0, 3, R);
        v(0, 0, 0, 0, 0, 3, P);
        v(0, 1, 0, 0, 0, 3, P);   // start ignored in PLAY

        // hit with simultaneous tick (not counted), gaps and ignored events
        v(0, 0, 1, 0, 1, 2, D);
        v(0, 0, 0, 0, 1, 2, D);   // tick 1
        v(0, 0, 0, 0, 0, 2, D);
        v(0, 1, 1, 1, 0, 2, D);   // start/hit/goal ignored while dying
        v(0, 0, 0, 0, 1, 2, D);   // tick 2
        v(0, 0, 0, 0, 1, 2, D);   // tick 3
        v(0, 0, 0, 0, 1, 2, R);   // tick 4
        v(0, 0, 0, 0, 0, 2, P);

        // goals 1,2 then hit+goal: goal must not count
        goal(2);
        goal(2);
        v(0, 0, 1, 1, 0, 1, D);
        v(0, 0, 0, 0, 1, 1, D);
        v(0, 0, 0, 0, 1, 1, D);
        v(0, 0, 0, 0, 1, 1, D);
        v(0, 0, 0, 0, 1, 1, R);
        v(0, 0, 0, 0, 0, 1, P);
        goal(1);                  // 3rd goal
        goal(2);                  // 4th goal: bonus 1 -> 2

        // bonus 2 -> 3, 3 -> 4, 4 -> 5, then saturation at 5
        goal(2); goal(2); goal(2); goal(3);
        goal(3); goal(3); goal(3); goal(4);
        goal(4); goal(4); goal(4); goal(5);
        goal(5); goal(5); goal(5); goal(5);

        // lose all lives
        death(4); death(3); death(2); death(1); death(0);
        v(0, 0, 1, 1, 1, 0, G);   // events ignored in GAMEOVER
        v(0, 1, 0, 0, 0, 3, R);   // restart
        v(0, 0, 0, 0, 0, 3, P);

        // reset mid-DYING after 2 ticks
        v(0, 0, 1, 0, 0, 2, D);
        v(0, 0, 0, 0, 1, 2, D);
        v(0, 0, 0, 0, 1, 2, D);
        v(1, 0, 1, 0, 1, 3, I);
        v(0, 0, 1, 0, 1, 3, I);
        v(0, 1, 0, 0, 0, 3, R);
        v(0, 0, 0, 0, 0, 3, P);
        death(2);                 // timer restarted from zero: full 4 ticks

        // reset during the respawn pulse
        v(0, 0, 0, 1, 0, 2, R);
        v(1, 0, 0, 0, 0, 3, I);

        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations left, want 0", q.size());
            total++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, want finish");
        $fatal(1, "timeout");
    end

endmodule
